// File: rtl/line_interp.sv
// Turns sparse tracked camera points into a dense, gap-free Bresenham pixel
// stream for the frame writer; handles pen-up, glitch jumps and off-screen samples.
module line_interp #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int MAX_JUMP = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] cam_x,
    input  logic [9:0] cam_y,
    input  logic       pen,
    input  logic       cam_valid,
    output logic       cam_ready,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic       px_valid,
    input  logic       px_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_DRAW  = 2'd2
    } state_t;

    localparam logic [10:0] H_LIM    = 11'(H_RES);
    localparam logic [10:0] V_LIM    = 11'(V_RES);
    localparam logic [10:0] JUMP_LIM = 11'(MAX_JUMP);

    state_t             r_state;
    logic               r_have_last;
    logic [9:0]         r_last_x;
    logic [9:0]         r_last_y;
    logic [9:0]         r_end_x;
    logic [9:0]         r_end_y;
    logic [9:0]         r_px_x;
    logic [9:0]         r_px_y;
    logic               r_px_valid;
    logic               r_cam_ready;
    logic               r_busy;
    logic signed [11:0] r_err;
    logic [10:0]        r_adx;
    logic [10:0]        r_ady;
    logic               r_neg_x;
    logic               r_neg_y;
    logic [10:0]        r_cnt;

    logic signed [10:0] w_acc_dx;
    logic signed [10:0] w_acc_dy;
    logic signed [10:0] w_su_dx;
    logic signed [10:0] w_su_dy;
    logic [10:0]        w_su_adx;
    logic [10:0]        w_su_ady;
    logic [10:0]        w_su_steps;
    logic               w_in_range;
    logic               w_jump;
    logic               w_same;
    logic signed [12:0] w_e2;
    logic signed [12:0] w_neg_ady;
    logic signed [12:0] w_pos_adx;
    logic               w_step_x;
    logic               w_step_y;
    logic signed [11:0] w_nerr;
    logic [9:0]         w_nx;
    logic [9:0]         w_ny;

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        abs11 = v[10] ? 11'(-v) : 11'(v);
    endfunction

    // Classification of an incoming sample against the last drawn point
    always_comb begin
        w_acc_dx   = $signed({1'b0, cam_x}) - $signed({1'b0, r_last_x});
        w_acc_dy   = $signed({1'b0, cam_y}) - $signed({1'b0, r_last_y});
        w_in_range = ({1'b0, cam_x} < H_LIM) && ({1'b0, cam_y} < V_LIM);
        w_jump     = (abs11(w_acc_dx) > JUMP_LIM) || (abs11(w_acc_dy) > JUMP_LIM);
        w_same     = (cam_x == r_last_x) && (cam_y == r_last_y);
    end

    // Line deltas from last point to endpoint; zero for the single-pixel case
    always_comb begin
        w_su_dx  = $signed({1'b0, r_end_x}) - $signed({1'b0, r_last_x});
        w_su_dy  = $signed({1'b0, r_end_y}) - $signed({1'b0, r_last_y});
        w_su_adx = abs11(w_su_dx);
        w_su_ady = abs11(w_su_dy);
        if (w_su_adx >= w_su_ady) begin
            w_su_steps = w_su_adx;
        end else begin
            w_su_steps = w_su_ady;
        end
    end

    // One Bresenham step from the currently presented pixel
    always_comb begin
        w_e2      = $signed({r_err, 1'b0});
        w_neg_ady = -$signed({2'b00, r_ady});
        w_pos_adx = $signed({2'b00, r_adx});
        w_step_x  = (w_e2 >= w_neg_ady);
        w_step_y  = (w_e2 <= w_pos_adx);
        w_nerr    = r_err - (w_step_x ? $signed({1'b0, r_ady}) : 12'sd0)
                          + (w_step_y ? $signed({1'b0, r_adx}) : 12'sd0);
        w_nx      = w_step_x ? (r_neg_x ? r_px_x - 10'd1 : r_px_x + 10'd1) : r_px_x;
        w_ny      = w_step_y ? (r_neg_y ? r_px_y - 10'd1 : r_px_y + 10'd1) : r_px_y;
    end

    // Control FSM, line state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_have_last <= 1'b0;
            r_last_x    <= 10'd0;
            r_last_y    <= 10'd0;
            r_end_x     <= 10'd0;
            r_end_y     <= 10'd0;
            r_px_x      <= 10'd0;
            r_px_y      <= 10'd0;
            r_px_valid  <= 1'b0;
            r_cam_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 12'sd0;
            r_adx       <= 11'd0;
            r_ady       <= 11'd0;
            r_neg_x     <= 1'b0;
            r_neg_y     <= 1'b0;
            r_cnt       <= 11'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cam_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    if (r_cam_ready && cam_valid) begin
                        if (!pen) begin
                            r_have_last <= 1'b0;
                        end else if (!w_in_range) begin
                            r_have_last <= r_have_last;
                        end else if (!r_have_last || w_jump) begin
                            // Restart the stroke: last == end yields a zero-step line
                            r_last_x    <= cam_x;
                            r_last_y    <= cam_y;
                            r_end_x     <= cam_x;
                            r_end_y     <= cam_y;
                            r_have_last <= 1'b1;
                            r_state     <= S_SETUP;
                            r_cam_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end else if (w_same) begin
                            r_have_last <= r_have_last;
                        end else begin
                            r_end_x     <= cam_x;
                            r_end_y     <= cam_y;
                            r_state     <= S_SETUP;
                            r_cam_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    r_adx   <= w_su_adx;
                    r_ady   <= w_su_ady;
                    r_neg_x <= w_su_dx[10];
                    r_neg_y <= w_su_dy[10];
                    r_err   <= $signed({1'b0, w_su_adx}) - $signed({1'b0, w_su_ady});
                    r_cnt   <= w_su_steps;
                    r_px_x  <= r_last_x;
                    r_px_y  <= r_last_y;
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    if (!r_px_valid) begin
                        // First pixel: the start point is never re-emitted
                        r_px_valid <= 1'b1;
                        if (r_cnt != 11'd0) begin
                            r_px_x <= w_nx;
                            r_px_y <= w_ny;
                            r_err  <= w_nerr;
                            r_cnt  <= r_cnt - 11'd1;
                        end
                    end else if (px_ready) begin
                        if (r_cnt == 11'd0) begin
                            r_px_valid <= 1'b0;
                            r_last_x   <= r_end_x;
                            r_last_y   <= r_end_y;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_px_x <= w_nx;
                            r_px_y <= w_ny;
                            r_err  <= w_nerr;
                            r_cnt  <= r_cnt - 11'd1;
                        end
                    end else begin
                        r_px_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_px_valid  <= 1'b0;
                    r_cam_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign cam_ready = r_cam_ready;
    assign px_x      = r_px_x;
    assign px_y      = r_px_y;
    assign px_valid  = r_px_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_line_interp.sv
// Self-checking bench for line_interp: directed scenarios plus randomized samples
// scored against a queue-based reference of the expected pixel stream.
module tb_line_interp;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] cam_x;
    logic [9:0] cam_y;
    logic       pen;
    logic       cam_valid;
    logic       cam_ready;
    logic [9:0] px_x;
    logic [9:0] px_y;
    logic       px_valid;
    logic       px_ready;
    logic       busy;

    always #5 clk = ~clk;

    line_interp dut (
        .clk       (clk),
        .reset     (reset),
        .cam_x     (cam_x),
        .cam_y     (cam_y),
        .pen       (pen),
        .cam_valid (cam_valid),
        .cam_ready (cam_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .busy      (busy)
    );

    int n_total = 0;
    int n_bad   = 0;
    int qx[$];
    int qy[$];
    int m_have = 0;
    int m_lx   = 0;
    int m_ly   = 0;
    int cyc = 0;
    int lat_start = 0;
    bit lat_armed = 1'b0;
    int xfer_cnt = 0;
    int xfer_first = 0;
    int xfer_last = 0;
    bit acc_flag = 1'b0;
    int rdy_mode = 0;
    int stall_x = -1;
    int stall_y = -1;
    int stall_left = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: what pixels a consumed sample should produce
    function automatic void model_accept(input int x, input int y, input int p);
        int dx, dy, sx, sy, adx, ady, err, cx, cy, steps, e2;
        if (p == 0) begin
            m_have = 0;
        end else if (x >= 640 || y >= 480) begin
            m_have = m_have;
        end else if (m_have == 0 || iabs(x - m_lx) > 64 || iabs(y - m_ly) > 64) begin
            qx.push_back(x);
            qy.push_back(y);
            m_lx = x; m_ly = y; m_have = 1;
        end else if (x == m_lx && y == m_ly) begin
            m_have = m_have;
        end else begin
            dx = x - m_lx; dy = y - m_ly;
            sx = (dx < 0) ? -1 : 1;
            sy = (dy < 0) ? -1 : 1;
            adx = iabs(dx); ady = iabs(dy);
            err = adx - ady;
            steps = (adx > ady) ? adx : ady;
            cx = m_lx; cy = m_ly;
            for (int i = 0; i < steps; i++) begin
                e2 = 2 * err;
                if (e2 >= -ady) begin err -= ady; cx += sx; end
                if (e2 <= adx) begin err += adx; cy += sy; end
                qx.push_back(cx);
                qy.push_back(cy);
            end
            m_lx = x; m_ly = y;
        end
    endfunction

    task automatic tick();
        logic pv, pr, cv, cr, rs, cp;
        int ox, oy, cx, cy, ex, ey;
        if (stall_left > 0 && px_valid === 1'b1 && int'(px_x) == stall_x && int'(px_y) == stall_y) begin
            px_ready = 1'b0;
            stall_left--;
        end else if (rdy_mode == 1) begin
            px_ready = ($urandom_range(0, 2) != 0);
        end else begin
            px_ready = 1'b1;
        end
        pv = px_valid; pr = px_ready; ox = int'(px_x); oy = int'(px_y);
        cv = cam_valid; cr = cam_ready; cx = int'(cam_x); cy = int'(cam_y);
        cp = pen; rs = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (rs === 1'b1) begin
            if (cv && cr) begin
                check_eq("accept_idle", qx.size(), 0);
                model_accept(cx, cy, int'(cp));
                acc_flag = 1'b1;
                if (qx.size() > 0) begin
                    lat_armed = 1'b1;
                    lat_start = cyc;
                end
            end
            if (pv && pr) begin
                check_eq("px_expected", int'(qx.size() > 0), 1);
                if (qx.size() > 0) begin
                    ex = qx.pop_front();
                    ey = qy.pop_front();
                    check_eq("px_x", ox, ex);
                    check_eq("px_y", oy, ey);
                end
                if (xfer_cnt == 0) xfer_first = cyc;
                xfer_last = cyc;
                xfer_cnt++;
            end
            if (pv && !pr) begin
                check_eq("hold_valid", int'(px_valid), 1);
                check_eq("hold_x", int'(px_x), ox);
                check_eq("hold_y", int'(px_y), oy);
            end
            if (lat_armed && px_valid) begin
                check_eq("latency", cyc - lat_start, 2);
                lat_armed = 1'b0;
            end
            if (px_valid) begin
                check_eq("busy_px", int'(busy), 1);
                check_eq("ready_px", int'(cam_ready), 0);
            end
        end
    endtask

    task automatic send(input int x, input int y, input int p);
        int guard = 0;
        cam_x = 10'(x);
        cam_y = 10'(y);
        pen = p[0];
        cam_valid = 1'b1;
        acc_flag = 1'b0;
        while (!acc_flag && guard < 500) begin
            tick();
            guard++;
        end
        check_eq("accept_timeout", int'(acc_flag), 1);
        cam_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((qx.size() > 0 || busy || !cam_ready) && guard < 500) begin
            tick();
            guard++;
        end
        check_eq("drain_timeout", int'(guard < 500), 1);
        check_eq("drain_pxv", int'(px_valid), 0);
    endtask

    initial begin
        int guard, r, x, y, p;
        reset = 1'b0; cam_valid = 1'b0; cam_x = 10'd0; cam_y = 10'd0;
        pen = 1'b0; px_ready = 1'b1;
        repeat (4) tick();
        check_eq("rst_pxv", int'(px_valid), 0);
        check_eq("rst_px_x", int'(px_x), 0);
        check_eq("rst_px_y", int'(px_y), 0);
        check_eq("rst_ready", int'(cam_ready), 0);
        check_eq("rst_busy", int'(busy), 0);
        reset = 1'b1;
        tick();

        // First point: single pixel
        xfer_cnt = 0;
        send(100, 50, 1);
        drain();
        check_eq("single_cnt", xfer_cnt, 1);
        check_eq("ready_after", int'(cam_ready), 1);

        // Short line at full throughput
        xfer_cnt = 0;
        send(105, 52, 1);
        drain();
        check_eq("line_cnt", xfer_cnt, 5);
        check_eq("line_span", xfer_last - xfer_first, 4);

        // Same line with a 3-cycle stall on (102,51)
        send(0, 0, 0);
        send(100, 50, 1);
        drain();
        stall_x = 102; stall_y = 51; stall_left = 3;
        xfer_cnt = 0;
        send(105, 52, 1);
        drain();
        check_eq("stall_cnt", xfer_cnt, 5);
        check_eq("stall_used", stall_left, 0);

        // Steep negative line, then a glitch jump
        send(0, 0, 0);
        send(10, 20, 1);
        drain();
        xfer_cnt = 0;
        send(8, 25, 1);
        drain();
        check_eq("steep_cnt", xfer_cnt, 5);
        xfer_cnt = 0;
        send(200, 25, 1);
        drain();
        check_eq("jump_cnt", xfer_cnt, 1);

        // Pen-up, off-screen and repeated samples
        send(0, 0, 0);
        xfer_cnt = 0;
        send(300, 300, 1);
        drain();
        check_eq("penup_cnt", xfer_cnt, 1);
        xfer_cnt = 0;
        send(640, 10, 1);
        drain();
        send(300, 300, 1);
        drain();
        check_eq("noout_cnt", xfer_cnt, 0);
        send(302, 301, 1);
        drain();
        check_eq("after_oor_cnt", xfer_cnt, 2);

        // Reset in the middle of a line
        send(0, 0, 0);
        send(0, 0, 1);
        drain();
        xfer_cnt = 0;
        send(60, 0, 1);
        guard = 0;
        while (xfer_cnt < 10 && guard < 200) begin
            tick();
            guard++;
        end
        check_eq("midline_reach", int'(xfer_cnt >= 10), 1);
        reset = 1'b0;
        tick();
        check_eq("midrst_pxv", int'(px_valid), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_ready", int'(cam_ready), 0);
        qx.delete(); qy.delete();
        m_have = 0; lat_armed = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        xfer_cnt = 0;
        send(5, 5, 1);
        drain();
        check_eq("post_rst_cnt", xfer_cnt, 1);

        // Randomized samples with random back-pressure
        rdy_mode = 1;
        for (int k = 0; k < 120; k++) begin
            r = int'($urandom_range(0, 15));
            p = 1;
            case (r)
                0: begin p = 0; x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479)); end
                1: begin x = int'($urandom_range(640, 1023)); y = int'($urandom_range(0, 479)); end
                2: begin x = int'($urandom_range(0, 639)); y = int'($urandom_range(480, 1023)); end
                3: begin x = m_lx; y = m_ly; end
                4: begin x = int'($urandom_range(0, 639)); y = int'($urandom_range(0, 479)); end
                default: begin
                    x = m_lx + int'($urandom_range(0, 140)) - 70;
                    y = m_ly + int'($urandom_range(0, 140)) - 70;
                    x = (x < 0) ? 0 : ((x > 639) ? 639 : x);
                    y = (y < 0) ? 0 : ((y > 479) ? 479 : y);
                end
            endcase
            send(x, y, p);
        end
        drain();
        rdy_mode = 0;
        repeat (5) tick();
        check_eq("final_queue", qx.size(), 0);
        check_eq("final_pxv", int'(px_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
